// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - request, hopper and coin handshake bundle for the change dispenser
interface change_dispenser_if #(
  parameter int COIN_W = 2
);
  logic              start;
  logic [4:0]        amount;
  logic              q_empty;
  logic              d_empty;
  logic              n_empty;
  logic              coin_ack;
  logic [COIN_W-1:0] coin;
  logic              coin_valid;
  logic              busy;
  logic              done;
  logic              err;
  logic [4:0]        remaining;

  modport master (
    output start, amount, q_empty, d_empty, n_empty, coin_ack,
    input  coin, coin_valid, busy, done, err, remaining
  );

  modport slave (
    input  start, amount, q_empty, d_empty, n_empty, coin_ack,
    output coin, coin_valid, busy, done, err, remaining
  );
endinterface

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy quarter/dime/nickel change dispenser with coin handshake
module change_dispenser #(
  parameter int COIN_W = 2
) (
  input logic             clk,
  input logic             rst,
  change_dispenser_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    ISSUE  = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_t;

  localparam logic [COIN_W-1:0] COIN_NONE    = COIN_W'(0);
  localparam logic [COIN_W-1:0] COIN_NICKEL  = COIN_W'(1);
  localparam logic [COIN_W-1:0] COIN_DIME    = COIN_W'(2);
  localparam logic [COIN_W-1:0] COIN_QUARTER = COIN_W'(3);

  state_t            state, state_nxt;
  logic [COIN_W-1:0] coin_q, coin_nxt;
  logic              valid_q, valid_nxt;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;
  logic              err_q, err_nxt;
  logic [4:0]        rem_q, rem_nxt;
  logic [4:0]        coin_value;

  // Cent value of the coin currently presented; subtracted on the ack edge.
  always_comb begin
    coin_value = 5'd0;
    case (coin_q)
      COIN_QUARTER: coin_value = 5'd25;
      COIN_DIME:    coin_value = 5'd10;
      COIN_NICKEL:  coin_value = 5'd5;
      default:      coin_value = 5'd0;
    endcase
  end

  // State register and registered outputs; reset abandons any coin in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      coin_q  <= COIN_NONE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rem_q   <= 5'd0;
    end else begin
      state   <= state_nxt;
      coin_q  <= coin_nxt;
      valid_q <= valid_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      rem_q   <= rem_nxt;
    end
  end

  // Next state and next output values; outputs follow the state being entered.
  always_comb begin
    state_nxt = state;
    coin_nxt  = coin_q;
    valid_nxt = valid_q;
    rem_nxt   = rem_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          rem_nxt   = bus.amount;
          state_nxt = SELECT;
        end
      end
      SELECT: begin
        if ((rem_q % 5'd5) != 5'd0) begin
          state_nxt = ERR;
        end else if (rem_q == 5'd0) begin
          state_nxt = DONE;
        end else if (rem_q >= 5'd25 && !bus.q_empty) begin
          coin_nxt  = COIN_QUARTER;
          valid_nxt = 1'b1;
          state_nxt = ISSUE;
        end else if (rem_q >= 5'd10 && !bus.d_empty) begin
          coin_nxt  = COIN_DIME;
          valid_nxt = 1'b1;
          state_nxt = ISSUE;
        end else if (rem_q >= 5'd5 && !bus.n_empty) begin
          coin_nxt  = COIN_NICKEL;
          valid_nxt = 1'b1;
          state_nxt = ISSUE;
        end else begin
          state_nxt = ERR;
        end
      end
      ISSUE: begin
        // Hopper flags are ignored here so a presented coin is never withdrawn.
        if (bus.coin_ack && valid_q) begin
          rem_nxt   = rem_q - coin_value;
          coin_nxt  = COIN_NONE;
          valid_nxt = 1'b0;
          state_nxt = SELECT;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
    err_nxt  = (state_nxt == ERR);
  end

  assign bus.coin       = coin_q;
  assign bus.coin_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.remaining  = rem_q;

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter: COIN_W, default 2, width of the coin code.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request to dispense amount; sampled only in IDLE.
REQ-005 SHALL have port: amount  input  5  change owed, in cents; valid with start.
REQ-006 SHALL have port: q_empty, d_empty, n_empty  input  1 each  quarter/dime/nickel hopper empty.
REQ-007 SHALL have port: coin_ack  input  1  hopper has taken the presented coin.
REQ-008 SHALL have port: coin  output  COIN_W  coin code: 00 none, 01 nickel, 10 dime, 11 quarter.
REQ-009 SHALL have port: coin_valid  output  1  coin is presented and held stable.
REQ-010 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port: done  output  1  one-cycle pulse, full amount dispensed.
REQ-012 SHALL have port: err  output  1  one-cycle pulse, request aborted.
REQ-013 SHALL have port: remaining  output  5  cents not yet dispensed.

Function
REQ-014 SHALL implement states IDLE, SELECT, ISSUE, DONE, ERR; all outputs SHALL be registered.
REQ-015 In IDLE, start=1 SHALL latch amount into remaining and go to SELECT on the next edge; start outside IDLE SHALL be ignored.
REQ-016 In SELECT, if remaining is not a multiple of 5, the block SHALL go to ERR.
REQ-017 In SELECT, remaining==0 SHALL go to DONE.
REQ-018 Otherwise, SELECT SHALL choose greedily, in this order: quarter if remaining>=25 and !q_empty; else dime if remaining>=10 and !d_empty; else nickel if remaining>=5 and !n_empty.
REQ-019 SELECT SHALL go to ERR if no coin qualifies.
REQ-020 Empty flags SHALL be sampled only in SELECT.
REQ-021 On a choice, SELECT SHALL go to ISSUE with coin=chosen code and coin_valid=1 on the same edge.
REQ-022 In ISSUE, coin and coin_valid SHALL hold stable until coin_ack=1.
REQ-023 On the ack edge, remaining SHALL decrease by the coin value (25/10/5), coin_valid SHALL go to 0, coin SHALL go to 00, and the state SHALL return to SELECT.
REQ-024 Each coin SHALL take a minimum of 2 cycles (SELECT + ISSUE).
REQ-025 coin_ack while coin_valid=0 SHALL be ignored.
REQ-026 Subtraction SHALL never underflow, because greedy selection guarantees value<=remaining.
REQ-027 DONE SHALL assert done for one cycle with remaining=0, then return to IDLE.
REQ-028 ERR SHALL assert err for one cycle, then return to IDLE.
REQ-029 remaining SHALL hold the undispensed amount after ERR until the next accepted start.
REQ-030 Start-to-first-coin_valid latency SHALL be 2 cycles.
REQ-031 amount=0 SHALL pulse done 2 cycles after start, with no coin issued.
REQ-032 A hopper going empty while its coin is presented in ISSUE SHALL NOT withdraw the coin; the block SHALL wait for ack.

Reset
REQ-033 rst=0 SHALL immediately force: state IDLE, coin=00, coin_valid=0, busy=0, done=0, err=0, remaining=0.
REQ-034 This SHALL hold from any state, including mid-ISSUE; the coin in progress SHALL be abandoned.
REQ-035 Reset deassertion SHALL be recognised on the next rising edge; the first start SHALL be accepted in the cycle after deassertion.

Verification
REQ-036 Test: amount=20, all stocked, ack 1 cycle after each valid -> coins 10,10, done pulse, remaining=0, no err.
REQ-037 Test: amount=30, all stocked -> coins 11 then 01; done; first coin_valid exactly 2 cycles after start.
REQ-038 Test: amount=30, q_empty=1 -> coins 10,10,10; done.
REQ-039 Test: amount=15, d_empty=1, n_empty=1 -> no coin, err pulse, remaining=15, busy low after.
REQ-040 Test: amount=7 -> err pulse 2 cycles after start, coin_valid never high, remaining=7; also amount=0 -> done, no coin.
REQ-041 Test: amount=25, coin_ack withheld 5 cycles then rst=0 mid-ISSUE -> coin_valid=0 and busy=0 immediately (asynchronously); later start with amount=5 -> single nickel, done.
